uart_cmd_parser: RTL and testbench



---
 rtl/uart_cmd_parser.sv | 227 ++++++++++++++++++++++
 tb/tb_uart_cmd_parser.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_cmd_parser.sv
// uart_cmd_parser
//   Assembles fixed-length command frames from a UART receiver byte stream.
//   The frame is SOF, CMD, ADDR, DATA_HI, DATA_LO and, when UART_CMD_CHKSUM_EN is
//   defined, a trailing XOR checksum byte. Each good frame is presented to the
//   consumer over a valid/ready handshake. Errors are reported as one-cycle pulses.
//
//   Build option: define UART_CMD_CHKSUM_EN for the 6-byte frame with checksum.
//   When it is undefined, the frame is 5 bytes and o_Chk_Err is tied low.
//
// Ports
//   i_CLK          system clock
//   i_RSTN         synchronous active-low reset
//   i_Rx_DV        byte strobe from the UART receiver (one cycle per byte)
//   i_Rx_Byte      received byte, valid while i_Rx_DV is high
//   o_Cmd_Valid    decoded command available
//   i_Cmd_Ready    consumer accepts the command
//   o_Cmd          command opcode
//   o_Addr         register address
//   o_Data         {DATA_HI, DATA_LO}
//   o_Chk_Err      pulse: checksum mismatch, frame dropped
//   o_Timeout_Err  pulse: inter-byte timeout, partial frame dropped
//   o_Overrun_Err  pulse: good frame dropped because a command was still pending
module uart_cmd_parser #(
  parameter logic [7:0]  SOF_BYTE     = 8'hA5,
  parameter int unsigned TIMEOUT_CLKS = 20000
) (
  input  logic        i_CLK,
  input  logic        i_RSTN,
  input  logic        i_Rx_DV,
  input  logic [7:0]  i_Rx_Byte,
  output logic        o_Cmd_Valid,
  input  logic        i_Cmd_Ready,
  output logic [7:0]  o_Cmd,
  output logic [7:0]  o_Addr,
  output logic [15:0] o_Data,
  output logic        o_Chk_Err,
  output logic        o_Timeout_Err,
  output logic        o_Overrun_Err
);

  typedef enum logic [2:0] {
    StSof, StCmd, StAddr, StDhi,
`ifdef UART_CMD_CHKSUM_EN
    StDlo, StChk
`else
    StDlo
`endif
  } state_e;

  localparam logic [15:0] TimeoutLast = 16'(TIMEOUT_CLKS - 1);

  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [7:0]  cmd_sh_q, cmd_sh_d;
  logic [7:0]  addr_sh_q, addr_sh_d;
  logic [7:0]  dhi_sh_q, dhi_sh_d;
  logic [7:0]  dlo_last;
  logic        valid_q, valid_d;
  logic [7:0]  cmd_q, cmd_d;
  logic [7:0]  addr_q, addr_d;
  logic [15:0] data_q, data_d;
  logic        to_err_q, to_err_d;
  logic        ov_err_q, ov_err_d;
  logic        frame_done;
  logic        load;
`ifdef UART_CMD_CHKSUM_EN
  logic [7:0]  acc_q, acc_d;
  logic [7:0]  dlo_sh_q, dlo_sh_d;
  logic        chk_err_q, chk_err_d;
`endif

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    cmd_sh_d   = cmd_sh_q;
    addr_sh_d  = addr_sh_q;
    dhi_sh_d   = dhi_sh_q;
    frame_done = 1'b0;
    to_err_d   = 1'b0;
`ifdef UART_CMD_CHKSUM_EN
    acc_d      = acc_q;
    dlo_sh_d   = dlo_sh_q;
    chk_err_d  = 1'b0;
    dlo_last   = dlo_sh_q;
`else
    // Without a checksum byte, DATA_LO completes the frame straight off the bus.
    dlo_last   = i_Rx_Byte;
`endif

    // Inter-byte timer: idle in StSof, cleared by any byte; a byte on the
    // terminal count wins over the timeout.
    if (state_q == StSof) begin
      cnt_d = '0;
    end else if (i_Rx_DV) begin
      cnt_d = '0;
    end else if (cnt_q == TimeoutLast) begin
      cnt_d    = '0;
      to_err_d = 1'b1;
      state_d  = StSof;
    end else begin
      cnt_d = cnt_q + 16'd1;
    end

    if (i_Rx_DV) begin
      unique case (state_q)
        StSof: begin
          if (i_Rx_Byte == SOF_BYTE) begin
            state_d = StCmd;
`ifdef UART_CMD_CHKSUM_EN
            acc_d   = '0;
`endif
          end
        end
        StCmd: begin
          cmd_sh_d = i_Rx_Byte;
          state_d  = StAddr;
`ifdef UART_CMD_CHKSUM_EN
          acc_d    = acc_q ^ i_Rx_Byte;
`endif
        end
        StAddr: begin
          addr_sh_d = i_Rx_Byte;
          state_d   = StDhi;
`ifdef UART_CMD_CHKSUM_EN
          acc_d     = acc_q ^ i_Rx_Byte;
`endif
        end
        StDhi: begin
          dhi_sh_d = i_Rx_Byte;
          state_d  = StDlo;
`ifdef UART_CMD_CHKSUM_EN
          acc_d    = acc_q ^ i_Rx_Byte;
`endif
        end
`ifdef UART_CMD_CHKSUM_EN
        StDlo: begin
          dlo_sh_d = i_Rx_Byte;
          acc_d    = acc_q ^ i_Rx_Byte;
          state_d  = StChk;
        end
        StChk: begin
          state_d = StSof;
          if (i_Rx_Byte == acc_q) begin
            frame_done = 1'b1;
          end else begin
            chk_err_d = 1'b1;
          end
        end
`else
        StDlo: begin
          state_d    = StSof;
          frame_done = 1'b1;
        end
`endif
        default: state_d = StSof;
      endcase
    end

    // A good frame loads only if the output slot is empty or being drained now.
    load     = frame_done && (!valid_q || i_Cmd_Ready);
    ov_err_d = frame_done && !load;

    valid_d = valid_q;
    cmd_d   = cmd_q;
    addr_d  = addr_q;
    data_d  = data_q;
    if (load) begin
      valid_d = 1'b1;
      cmd_d   = cmd_sh_q;
      addr_d  = addr_sh_q;
      data_d  = {dhi_sh_q, dlo_last};
    end else if (valid_q && i_Cmd_Ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge i_CLK) begin
    if (!i_RSTN) begin
      state_q   <= StSof;
      cnt_q     <= '0;
      cmd_sh_q  <= '0;
      addr_sh_q <= '0;
      dhi_sh_q  <= '0;
      valid_q   <= 1'b0;
      cmd_q     <= '0;
      addr_q    <= '0;
      data_q    <= '0;
      to_err_q  <= 1'b0;
      ov_err_q  <= 1'b0;
`ifdef UART_CMD_CHKSUM_EN
      acc_q     <= '0;
      dlo_sh_q  <= '0;
      chk_err_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      cmd_sh_q  <= cmd_sh_d;
      addr_sh_q <= addr_sh_d;
      dhi_sh_q  <= dhi_sh_d;
      valid_q   <= valid_d;
      cmd_q     <= cmd_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      to_err_q  <= to_err_d;
      ov_err_q  <= ov_err_d;
`ifdef UART_CMD_CHKSUM_EN
      acc_q     <= acc_d;
      dlo_sh_q  <= dlo_sh_d;
      chk_err_q <= chk_err_d;
`endif
    end
  end

  assign o_Cmd_Valid   = valid_q;
  assign o_Cmd         = cmd_q;
  assign o_Addr        = addr_q;
  assign o_Data        = data_q;
  assign o_Timeout_Err = to_err_q;
  assign o_Overrun_Err = ov_err_q;
`ifdef UART_CMD_CHKSUM_EN
  assign o_Chk_Err     = chk_err_q;
`else
  assign o_Chk_Err     = 1'b0;
`endif

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Directed bench for uart_cmd_parser. Inputs change on the falling edge, outputs are
// checked on the falling edge after the strobe's rising edge. Honors UART_CMD_CHKSUM_EN
// so the same bench covers both frame formats.
module tb_uart_cmd_parser;

  logic        i_CLK = 1'b0;
  logic        i_RSTN;
  logic        i_Rx_DV;
  logic [7:0]  i_Rx_Byte;
  logic        o_Cmd_Valid;
  logic        i_Cmd_Ready;
  logic [7:0]  o_Cmd;
  logic [7:0]  o_Addr;
  logic [15:0] o_Data;
  logic        o_Chk_Err;
  logic        o_Timeout_Err;
  logic        o_Overrun_Err;

  int vectors     = 0;
  int miscompares = 0;
  int n_chk = 0;
  int n_to  = 0;
  int n_ov  = 0;
  int n;

  uart_cmd_parser dut (
    .i_CLK         (i_CLK),
    .i_RSTN        (i_RSTN),
    .i_Rx_DV       (i_Rx_DV),
    .i_Rx_Byte     (i_Rx_Byte),
    .o_Cmd_Valid   (o_Cmd_Valid),
    .i_Cmd_Ready   (i_Cmd_Ready),
    .o_Cmd         (o_Cmd),
    .o_Addr        (o_Addr),
    .o_Data        (o_Data),
    .o_Chk_Err     (o_Chk_Err),
    .o_Timeout_Err (o_Timeout_Err),
    .o_Overrun_Err (o_Overrun_Err)
  );

  always #5 i_CLK = ~i_CLK;

  // Pulse-cycle counters; reading before the NBA update sees last cycle's outputs.
  always @(posedge i_CLK) begin
    if (o_Chk_Err)     n_chk++;
    if (o_Timeout_Err) n_to++;
    if (o_Overrun_Err) n_ov++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge i_CLK);
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    @(negedge i_CLK);
    i_Rx_DV   = 1'b1;
    i_Rx_Byte = b;
    @(negedge i_CLK);
    i_Rx_DV   = 1'b0;
    repeat (gap) @(negedge i_CLK);
  endtask

  // Returns on the falling edge right after the final byte's strobe edge.
  task automatic send_frame(input logic [7:0] c, input logic [7:0] a, input logic [7:0] h,
                            input logic [7:0] l, input logic [7:0] k, input int gap);
    send_byte(8'hA5, gap);
    send_byte(c, gap);
    send_byte(a, gap);
    send_byte(h, gap);
`ifdef UART_CMD_CHKSUM_EN
    send_byte(l, gap);
    send_byte(k, 0);
`else
    if (k == 8'hFF) $display("note: checksum byte %0h unused in this build", k);
    send_byte(l, 0);
`endif
  endtask

  initial begin
    i_RSTN      = 1'b0;
    i_Rx_DV     = 1'b0;
    i_Rx_Byte   = 8'h00;
    i_Cmd_Ready = 1'b1;
    repeat (3) tick();

    // Reset state
    check("rst_valid", o_Cmd_Valid, 0);
    check("rst_cmd", o_Cmd, 0);
    check("rst_addr", o_Addr, 0);
    check("rst_data", o_Data, 0);
    check("rst_errs", {o_Chk_Err, o_Timeout_Err, o_Overrun_Err}, 0);
    i_RSTN = 1'b1;

    // Good frame at 216 clks/bit spacing
    send_frame(8'h01, 8'h10, 8'h12, 8'h34, 8'h37, 2160);
    check("t1_valid", o_Cmd_Valid, 1);
    check("t1_cmd", o_Cmd, 32'h01);
    check("t1_addr", o_Addr, 32'h10);
    check("t1_data", o_Data, 32'h1234);
    tick();
    check("t1_valid_clr", o_Cmd_Valid, 0);
    repeat (2) tick();
    check("t1_no_errs", n_chk + n_to + n_ov, 0);

`ifdef UART_CMD_CHKSUM_EN
    // Bad checksum, then a good frame
    send_frame(8'h01, 8'h10, 8'h12, 8'h34, 8'h38, 20);
    check("t2_chk_pulse", o_Chk_Err, 1);
    check("t2_no_valid", o_Cmd_Valid, 0);
    tick();
    check("t2_chk_end", o_Chk_Err, 0);
    send_frame(8'h01, 8'h10, 8'h12, 8'h34, 8'h37, 20);
    check("t2_good_valid", o_Cmd_Valid, 1);
    check("t2_good_data", o_Data, 32'h1234);
    repeat (2) tick();
    check("t2_chk_count", n_chk, 1);
`endif

    // Leading garbage ignored
    send_byte(8'h00, 5);
    send_byte(8'hFF, 5);
    send_frame(8'h01, 8'h10, 8'h12, 8'h34, 8'h37, 5);
    check("t3_valid", o_Cmd_Valid, 1);
    check("t3_cmd", o_Cmd, 32'h01);
    tick();
    check("t3_valid_clr", o_Cmd_Valid, 0);

    // Inter-byte timeout: pulse 20000 clocks after the last byte's strobe edge
    send_byte(8'hA5, 3);
    send_byte(8'h01, 3);
    send_byte(8'h10, 0);
    n = 0;
    for (int i = 0; i < 25000; i++) begin
      tick();
      n++;
      if (o_Timeout_Err) break;
    end
    check("t4_to_latency", n, 20000);
    tick();
    check("t4_to_end", o_Timeout_Err, 0);
    send_frame(8'h01, 8'h10, 8'h12, 8'h34, 8'h37, 4);
    check("t4_after_valid", o_Cmd_Valid, 1);
    check("t4_after_addr", o_Addr, 32'h10);
    repeat (2) tick();
    check("t4_to_count", n_to, 1);

    // Byte on the terminal-count cycle wins over the timeout
    send_byte(8'hA5, 19998);
    send_byte(8'h01, 2);
    send_byte(8'h10, 2);
    send_byte(8'h12, 2);
`ifdef UART_CMD_CHKSUM_EN
    send_byte(8'h34, 2);
    send_byte(8'h37, 0);
`else
    send_byte(8'h34, 0);
`endif
    check("t5_valid", o_Cmd_Valid, 1);
    check("t5_data", o_Data, 32'h1234);
    repeat (2) tick();
    check("t5_to_count", n_to, 1);

    // Overrun: second frame dropped while first is held
    i_Cmd_Ready = 1'b0;
    send_frame(8'h01, 8'h10, 8'h12, 8'h34, 8'h37, 5);
    check("t6_first_valid", o_Cmd_Valid, 1);
    repeat (3) tick();
    send_frame(8'h02, 8'h20, 8'hAB, 8'hCD, 8'h44, 5);
    check("t6_ov_pulse", o_Overrun_Err, 1);
    check("t6_held_valid", o_Cmd_Valid, 1);
    check("t6_held_cmd", o_Cmd, 32'h01);
    check("t6_held_addr", o_Addr, 32'h10);
    check("t6_held_data", o_Data, 32'h1234);
    tick();
    check("t6_ov_end", o_Overrun_Err, 0);
    i_Cmd_Ready = 1'b1;
    tick();
    check("t6_valid_clr", o_Cmd_Valid, 0);
    repeat (2) tick();
    check("t6_ov_count", n_ov, 1);

    // Reset mid-frame with a command pending
    i_Cmd_Ready = 1'b0;
    send_frame(8'h02, 8'h20, 8'hAB, 8'hCD, 8'h44, 3);
    check("t7_pending", o_Cmd_Valid, 1);
    send_byte(8'hA5, 2);
    send_byte(8'h01, 2);
    @(negedge i_CLK);
    i_RSTN = 1'b0;
    @(negedge i_CLK);
    i_RSTN = 1'b1;
    check("t7_rst_valid", o_Cmd_Valid, 0);
    check("t7_rst_cmd", o_Cmd, 0);
    check("t7_rst_data", o_Data, 0);
    i_Cmd_Ready = 1'b1;
    send_byte(8'h10, 3);
    send_byte(8'h12, 3);
    send_byte(8'h34, 3);
    send_byte(8'h37, 0);
    check("t7_no_cmd", o_Cmd_Valid, 0);
    repeat (5) tick();
    check("t7_no_cmd_late", {o_Cmd_Valid, o_Cmd}, 0);
    send_frame(8'h02, 8'h20, 8'hAB, 8'hCD, 8'h44, 3);
    check("t7_recover_cmd", o_Cmd, 32'h02);
    check("t7_recover_data", o_Data, 32'hABCD);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
